// File: rtl/axil_arb_pkg.sv
// Shared definitions for the AXI4-lite arbiters.
//   arb_state_t : arbiter FSM encoding (IDLE=0, ADDR=1, DATA=2, RESP=3)
//   sel_width() : grant index width for n requesters, never less than 1 bit
package axil_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } arb_state_t;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axil_rr_select.sv
// Combinational round-robin selector.
//   req          : request vector, one bit per requester
//   ptr          : index of the requester with highest priority this cycle
//   grant_onehot : one-hot grant, zero when nothing is requested
//   grant_idx    : binary index of the granted requester
//   grant_valid  : at least one request present
// The winner is the first asserted request at or after ptr, wrapping past S_COUNT-1.
module axil_rr_select
  import axil_arb_pkg::*;
#(
  parameter  int S_COUNT    = 4,
  localparam int CL_S_COUNT = sel_width(S_COUNT)
) (
  input  logic [S_COUNT-1:0]    req,
  input  logic [CL_S_COUNT-1:0] ptr,
  output logic [S_COUNT-1:0]    grant_onehot,
  output logic [CL_S_COUNT-1:0] grant_idx,
  output logic                  grant_valid
);

  logic [CL_S_COUNT:0]   sum;
  logic [CL_S_COUNT-1:0] idx;

  // Scan from the furthest candidate back towards ptr so the nearest
  // asserted request overwrites any earlier hit.
  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    grant_valid  = 1'b0;
    sum          = '0;
    idx          = '0;
    for (int i = S_COUNT - 1; i >= 0; i--) begin
      sum = {1'b0, ptr} + (CL_S_COUNT + 1)'(i);
      if (sum >= (CL_S_COUNT + 1)'(S_COUNT)) begin
        sum = sum - (CL_S_COUNT + 1)'(S_COUNT);
      end
      idx = sum[CL_S_COUNT-1:0];
      if (req[idx]) begin
        grant_onehot      = '0;
        grant_onehot[idx] = 1'b1;
        grant_idx         = idx;
        grant_valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axil_rd_arbiter.sv
// Round-robin AXI4-lite read arbiter: S_COUNT requesters share one read master
// port, one transaction outstanding at a time.
//   clk, rst_n        : clock, asynchronous active-low reset
//   s_axil_ar*        : per-requester read address channels (flattened vectors)
//   s_axil_r*         : read data/resp broadcast, per-requester rvalid/rready
//   m_axil_ar*/r*     : downstream read master port
//   dbg_state         : current FSM state (arb_state_t encoding)
// Handshake rule on every channel: a beat transfers on a rising edge where
// valid and ready are both 1; valid, once raised, holds with stable payload
// until that edge.
module axil_rd_arbiter
  import axil_arb_pkg::*;
#(
  parameter int S_COUNT    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [S_COUNT*ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic [S_COUNT*3-1:0]          s_axil_arprot,
  input  logic [S_COUNT-1:0]            s_axil_arvalid,
  output logic [S_COUNT-1:0]            s_axil_arready,
  output logic [DATA_WIDTH-1:0]         s_axil_rdata,
  output logic [1:0]                    s_axil_rresp,
  output logic [S_COUNT-1:0]            s_axil_rvalid,
  input  logic [S_COUNT-1:0]            s_axil_rready,
  output logic [ADDR_WIDTH-1:0]         m_axil_araddr,
  output logic [2:0]                    m_axil_arprot,
  output logic                          m_axil_arvalid,
  input  logic                          m_axil_arready,
  input  logic [DATA_WIDTH-1:0]         m_axil_rdata,
  input  logic [1:0]                    m_axil_rresp,
  input  logic                          m_axil_rvalid,
  output logic                          m_axil_rready,
  output logic [1:0]                    dbg_state
);

  localparam int CL_S_COUNT = sel_width(S_COUNT);

  arb_state_t state_q, state_d;

  logic [CL_S_COUNT-1:0] grant_q;
  logic [CL_S_COUNT-1:0] ptr_q;
  logic [ADDR_WIDTH-1:0] araddr_q;
  logic [2:0]            arprot_q;
  logic                  arvalid_q;
  logic                  rready_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;
  logic [S_COUNT-1:0]    rvalid_q;

  logic [S_COUNT-1:0]    sel_onehot;
  logic [CL_S_COUNT-1:0] sel_idx;
  logic                  sel_valid;

  logic [ADDR_WIDTH-1:0] araddr_arr [S_COUNT];
  logic [2:0]            arprot_arr [S_COUNT];

  for (genvar g = 0; g < S_COUNT; g++) begin : g_unpack
    assign araddr_arr[g] = s_axil_araddr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign arprot_arr[g] = s_axil_arprot[g*3 +: 3];
  end

  axil_rr_select #(
    .S_COUNT (S_COUNT)
  ) u_select (
    .req          (s_axil_arvalid),
    .ptr          (ptr_q),
    .grant_onehot (sel_onehot),
    .grant_idx    (sel_idx),
    .grant_valid  (sel_valid)
  );

  // Grant is only offered while idle; rst_n gating keeps arready low
  // during reset even though the state register already reads IDLE.
  assign s_axil_arready = (state_q == ST_IDLE && rst_n) ? sel_onehot : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (sel_valid)                 state_d = ST_ADDR;
      ST_ADDR: if (m_axil_arready)            state_d = ST_DATA;
      ST_DATA: if (m_axil_rvalid)             state_d = ST_RESP;
      ST_RESP: if (s_axil_rready[grant_q])    state_d = ST_IDLE;
      default:                                state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q   <= '0;
      ptr_q     <= '0;
      araddr_q  <= '0;
      arprot_q  <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      rvalid_q  <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (sel_valid) begin
            grant_q   <= sel_idx;
            araddr_q  <= araddr_arr[sel_idx];
            arprot_q  <= arprot_arr[sel_idx];
            arvalid_q <= 1'b1;
          end
        end
        ST_ADDR: begin
          if (m_axil_arready) begin
            arvalid_q <= 1'b0;
            // rready rises together with entry into DATA.
            rready_q  <= 1'b1;
          end
        end
        ST_DATA: begin
          if (m_axil_rvalid) begin
            rdata_q  <= m_axil_rdata;
            rresp_q  <= m_axil_rresp;
            rvalid_q <= S_COUNT'(1) << grant_q;
            rready_q <= 1'b0;
          end
        end
        ST_RESP: begin
          if (s_axil_rready[grant_q]) begin
            rvalid_q <= '0;
            // Priority moves just past the port that was served.
            ptr_q    <= (grant_q == CL_S_COUNT'(S_COUNT - 1)) ? '0 : grant_q + 1'b1;
          end
        end
        default: begin
          arvalid_q <= 1'b0;
          rready_q  <= 1'b0;
          rvalid_q  <= '0;
        end
      endcase
    end
  end

  assign m_axil_araddr  = araddr_q;
  assign m_axil_arprot  = arprot_q;
  assign m_axil_arvalid = arvalid_q;
  assign m_axil_rready  = rready_q;
  assign s_axil_rdata   = rdata_q;
  assign s_axil_rresp   = rresp_q;
  assign s_axil_rvalid  = rvalid_q;
  assign dbg_state      = state_q;

endmodule
